// File: rtl/mips16_pc_pkg.sv
// mips16_pc_pkg: shared defaults and the next-PC source encoding for pc_sequencer
//   DEF_AW, DEF_OFS_W, DEF_STK_DEPTH : default parameter values
//   PC_MAX                           : highest address at the default width
//   pc_op_e                          : which request wins the next-PC priority
package mips16_pc_pkg;
  localparam int DEF_AW = 10;
  localparam int DEF_OFS_W = 8;
  localparam int DEF_STK_DEPTH = 4;
  localparam logic [DEF_AW-1:0] PC_MAX = {DEF_AW{1'b1}};
  typedef enum logic [2:0] {OP_BACK, OP_RET, OP_CALL, OP_JMP, OP_BR, OP_INC} pc_op_e;
endpackage

// File: rtl/pc_retstack.sv
// pc_retstack: LIFO return-address stack
//   clk, Clear_n : clock, async active-low reset (pointer and contents cleared)
//   push, din    : store din when not full
//   pop          : drop top entry when not empty
//   dout         : top entry ('0 when empty)
//   full, empty  : combinational from the pointer
module pc_retstack #(
  parameter int AW = 10,
  parameter int STK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          Clear_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(STK_DEPTH + 1);
  logic [PW-1:0] sp;
  logic [AW-1:0] mem [STK_DEPTH];
  assign full = sp == PW'(STK_DEPTH);
  assign empty = sp == '0;
  // sp counts entries, so the top lives at slot sp-1
  always_comb begin
    dout = '0;
    for (int i = 0; i < STK_DEPTH; i++) dout = (sp == PW'(i + 1)) ? mem[i] : dout;
  end
  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      sp <= '0;
      for (int i = 0; i < STK_DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      for (int i = 0; i < STK_DEPTH; i++) if (sp == PW'(i)) mem[i] <= din;
      sp <= sp + PW'(1);
    end else if (pop && !empty) begin
      sp <= sp - PW'(1);
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with branch, call/return stack and halt
//   clk, Clear_n        : clock, async active-low reset
//   step_en             : advance strobe; all state holds when low
//   backclk/Ret/Call/Jflag/Bflag : requests, in that priority order, above increment
//   Jaddr, Bofs, Enloop : jump target, signed branch offset, wrap-at-max enable
//   Caddr               : current address
//   halted, stk_full, stk_empty, stk_err : status (stk_err sticky until reset)
module pc_sequencer import mips16_pc_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int OFS_W = DEF_OFS_W,
  parameter int STK_DEPTH = DEF_STK_DEPTH
) (
  input  logic             clk,
  input  logic             Clear_n,
  input  logic             step_en,
  input  logic             backclk,
  input  logic             Jflag,
  input  logic [AW-1:0]    Jaddr,
  input  logic             Bflag,
  input  logic [OFS_W-1:0] Bofs,
  input  logic             Call,
  input  logic             Ret,
  input  logic             Enloop,
  output logic [AW-1:0]    Caddr,
  output logic             halted,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);
  localparam logic [AW-1:0] MAX = {AW{1'b1}};
  pc_op_e op;
  logic [AW-1:0] nxt, top;
  logic push, pop, err_set;
  assign halted = Caddr == MAX && !Enloop;
  always_comb begin
    op = backclk ? OP_BACK : Ret ? OP_RET : Call ? OP_CALL : Jflag ? OP_JMP : Bflag ? OP_BR : OP_INC;
    push = step_en && op == OP_CALL && !stk_full;
    pop = step_en && op == OP_RET && !stk_empty;
    err_set = step_en && ((op == OP_CALL && stk_full) || (op == OP_RET && stk_empty));
    // size cast of a signed operand sign-extends the offset to AW bits
    nxt = op == OP_BACK ? (Caddr == '0 ? '0 : Caddr - AW'(1)) :
          op == OP_RET  ? (stk_empty ? Caddr : top) :
          op == OP_CALL ? (stk_full ? Caddr : Jaddr) :
          op == OP_JMP  ? Jaddr :
          op == OP_BR   ? Caddr + AW'($signed(Bofs)) :
          Caddr == MAX  ? (Enloop ? '0 : Caddr) : Caddr + AW'(1);
  end
  pc_retstack #(.AW(AW), .STK_DEPTH(STK_DEPTH)) u_stk (
    .clk(clk), .Clear_n(Clear_n), .push(push), .pop(pop), .din(Caddr + AW'(1)),
    .dout(top), .full(stk_full), .empty(stk_empty)
  );
  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      Caddr <= '0;
      stk_err <= 1'b0;
    end else begin
      if (step_en) Caddr <= nxt;
      if (err_set) stk_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer against a behavioural PC/stack model
module tb_pc_sequencer;
  import mips16_pc_pkg::*;
  logic clk = 0, Clear_n = 0, step_en = 0, backclk = 0, Jflag = 0, Bflag = 0, Call = 0, Ret = 0, Enloop = 0;
  logic [9:0] Jaddr = '0;
  logic [7:0] Bofs = '0;
  logic [9:0] Caddr;
  logic halted, stk_full, stk_empty, stk_err;
  typedef struct {logic [9:0] pc; logic h, f, e, r;} exp_t;
  exp_t sb[$];
  int m_pc = 0;
  int m_stk[$];
  bit m_err = 0;
  int n_cmp = 0, n_bad = 0;

  pc_sequencer dut (
    .clk(clk), .Clear_n(Clear_n), .step_en(step_en), .backclk(backclk), .Jflag(Jflag), .Jaddr(Jaddr),
    .Bflag(Bflag), .Bofs(Bofs), .Call(Call), .Ret(Ret), .Enloop(Enloop), .Caddr(Caddr), .halted(halted),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input bit se, bk, rt, cl, jf, input logic [9:0] ja,
                      input bit bf, input logic [7:0] bo, input bit el);
    exp_t e;
    @(negedge clk);
    step_en = se; backclk = bk; Ret = rt; Call = cl; Jflag = jf; Jaddr = ja; Bflag = bf; Bofs = bo; Enloop = el;
    if (se) begin
      if (bk) m_pc = m_pc == 0 ? 0 : m_pc - 1;
      else if (rt) begin
        if (m_stk.size() == 0) m_err = 1; else m_pc = m_stk.pop_back();
      end else if (cl) begin
        if (m_stk.size() == 4) m_err = 1;
        else begin m_stk.push_back((m_pc + 1) % 1024); m_pc = int'(ja); end
      end else if (jf) m_pc = int'(ja);
      else if (bf) m_pc = (m_pc + int'($signed(bo))) & 1023;
      else m_pc = m_pc == 1023 ? (el ? 0 : 1023) : m_pc + 1;
    end
    e.pc = 10'(m_pc); e.h = m_pc == 1023 && !el; e.f = m_stk.size() == 4; e.e = m_stk.size() == 0; e.r = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"}, 32'(Caddr), 32'(e.pc));
    chk({tag, ".halt"}, 32'(halted), 32'(e.h));
    chk({tag, ".full"}, 32'(stk_full), 32'(e.f));
    chk({tag, ".empty"}, 32'(stk_empty), 32'(e.e));
    chk({tag, ".err"}, 32'(stk_err), 32'(e.r));
  endtask

  task automatic inc(input string tag, input bit se);
    step(tag, se, 0, 0, 0, 0, '0, 0, '0, 1);
  endtask

  task automatic jmp(input logic [9:0] a);
    step("jmp", 1, 0, 0, 0, 1, a, 0, '0, 1);
  endtask

  initial begin
    #1;
    chk("rst.pc", 32'(Caddr), 0);
    chk("rst.empty", 32'(stk_empty), 1);
    chk("rst.full", 32'(stk_full), 0);
    chk("rst.err", 32'(stk_err), 0);
    #11 Clear_n = 1;
    for (int i = 0; i < 5; i++) inc("t1.inc", 1);
    chk("t1.five", 32'(Caddr), 5);
    for (int i = 0; i < 3; i++) inc("t1.hold", 0);
    chk("t1.held", 32'(Caddr), 5);
    jmp(PC_MAX);
    step("t2.halt", 1, 0, 0, 0, 0, '0, 0, '0, 0);
    chk("t2.halt_pc", 32'(Caddr), 1023);
    chk("t2.halted", 32'(halted), 1);
    step("t2.wrap", 1, 0, 0, 0, 0, '0, 0, '0, 1);
    chk("t2.wrap_pc", 32'(Caddr), 0);
    jmp(10);
    step("t3.neg", 1, 0, 0, 0, 0, '0, 1, 8'(-12), 1);
    chk("t3.neg_pc", 32'(Caddr), 1022);
    step("t3.pos", 1, 0, 0, 0, 0, '0, 1, 8'd5, 1);
    chk("t3.pos_pc", 32'(Caddr), 3);
    jmp(20);
    step("t4.call", 1, 0, 0, 1, 0, 10'd100, 0, '0, 1);
    chk("t4.call_pc", 32'(Caddr), 100);
    step("t4.ret", 1, 0, 1, 0, 0, '0, 0, '0, 1);
    chk("t4.ret_pc", 32'(Caddr), 21);
    chk("t4.ret_empty", 32'(stk_empty), 1);
    for (int i = 0; i < 5; i++) step("t4.nest", 1, 0, 0, 1, 0, 10'(200 + 100 * i), 0, '0, 1);
    chk("t4.ovf_pc", 32'(Caddr), 500);
    chk("t4.ovf_err", 32'(stk_err), 1);
    jmp(0);
    step("t5.back0", 1, 1, 0, 0, 0, '0, 0, '0, 1);
    chk("t5.back0_pc", 32'(Caddr), 0);
    jmp(7);
    step("t5.prio", 1, 1, 0, 1, 1, 10'd300, 0, '0, 1);
    chk("t5.prio_pc", 32'(Caddr), 6);
    chk("t5.prio_full", 32'(stk_full), 1);
    @(posedge clk);
    #2 Clear_n = 0;
    #1;
    chk("t6.pc", 32'(Caddr), 0);
    chk("t6.empty", 32'(stk_empty), 1);
    chk("t6.err", 32'(stk_err), 0);
    m_pc = 0; m_stk.delete(); m_err = 0;
    #1 Clear_n = 1;
    step("t6.after", 1, 0, 1, 0, 0, '0, 0, '0, 1);
    for (int i = 0; i < 60; i++)
      step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, 10'($urandom),
           $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 1) == 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
